// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - extension mode encodings shared by the immediate extender
package imm_ext_pkg;

    typedef enum logic [1:0] {
        MODE_SIGN  = 2'b00,
        MODE_ZERO  = 2'b01,
        MODE_BR    = 2'b10,
        MODE_UPPER = 2'b11
    } imm_mode_t;

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational immediate extension (sign/zero/branch/upper)
module imm_ext_core #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
);
    import imm_ext_pkg::*;

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;

    assign sext = {{PAD_W{imm[IN_W-1]}}, imm};

    always_comb begin
        ext = sext;
        case (imm_mode_t'(mode))
            MODE_SIGN:  ext = sext;
            MODE_ZERO:  ext = {{PAD_W{1'b0}}, imm};
            // Branch offsets are word counts; the top two sign bits fall off
            MODE_BR:    ext = {sext[OUT_W-3:0], 2'b00};
            MODE_UPPER: ext = {imm, {PAD_W{1'b0}}};
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate extender with tagged result FIFO and valid/ready handshake
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_imm,
    input  logic [1:0]                 in_mode,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import imm_ext_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [OUT_W-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           in_entry;
    entry_t           head_next;
    logic [OUT_W-1:0] ext;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_inc;
    logic [PW-1:0]    wr_ptr_inc;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .ext  (ext)
    );

    // Readiness depends on occupancy only, so a full FIFO never sees out_ready
    assign in_ready   = (count < CW'(DEPTH));
    assign out_valid  = (count != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign in_entry   = '{tag: in_tag, data: ext};
    assign rd_ptr_inc = wrap_inc(rd_ptr);
    assign wr_ptr_inc = wrap_inc(wr_ptr);

    // Head register: holds its value when the FIFO drains
    always_comb begin
        head_next = '{tag: out_tag, data: out_data};
        if (!out_valid && push) begin
            head_next = in_entry;
        end else if (pop && count > CW'(1)) begin
            head_next = mem[rd_ptr_inc];
        end else if (pop && push) begin
            head_next = in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            out_data <= head_next.data;
            out_tag  <= head_next.tag;
        end
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate-extension unit for the MIPS datapath. It generalises the plain 16→32 sign extender with configurable widths, four extension modes and a valid/ready handshake. Results are buffered in a small FIFO so that decode-stage stalls do not drop operands. It sits between instruction decode and the ALU operand mux, and carries a tag so downstream logic can match each result to its instruction.

Parameters:
IN_W, 16, immediate input width (≥2)
OUT_W, 32, extended output width; must satisfy OUT_W ≥ IN_W+2
DEPTH, 2, result FIFO entries (≥1; power of two not required)
TAG_W, 5, width of opaque tag carried alongside each operand (e.g. destination register)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input operand valid
in_ready  out  1  unit can accept an operand this cycle
in_imm  in  IN_W  raw immediate field
in_mode  in  2  extension mode (see package constants)
in_tag  in  TAG_W  tag, passed through unchanged
out_valid  out  1  head-of-FIFO result valid
out_ready  in  1  consumer accepts result this cycle
out_data  out  OUT_W  extended immediate
out_tag  out  TAG_W  tag of out_data
count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): count=0, out_valid=0, out_data=0, out_tag=0, read/write pointers=0; in_ready=1 after release.
- Modes, computed combinationally at enqueue and stored as a finished result:
  - MODE_SIGN=2'b00: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
  - MODE_ZERO=2'b01: zero-fill the upper bits.
  - MODE_BR=2'b10: sign-extend, then shift left 2; bits shifted past OUT_W-1 are discarded.
  - MODE_UPPER=2'b11: place in_imm at [OUT_W-1 : OUT_W-IN_W]; lower bits are 0.
- Push on in_valid && in_ready. Pop on out_valid && out_ready.
- in_ready = (count < DEPTH). It is registered-state driven only, with no combinational path from out_ready, so a full FIFO refuses input even when a pop occurs in the same cycle.
- out_valid = (count != 0). out_data and out_tag always show the head entry; when out_valid=0 they hold their last value.
- Latency: an operand accepted at edge t is visible with out_valid=1 after edge t. There is no same-cycle bypass.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Push and pop with count=0: only the push is possible, so count becomes 1.
- Pointers wrap from DEPTH-1 to 0. This must work for non-power-of-two DEPTH.
- in_valid while in_ready=0: ignored. The producer must hold its inputs, and the unit does not latch them.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_tag must not change.
- rst_n asserted mid-stream: all entries are discarded immediately and outputs return to reset values asynchronously.

Decomposition:
- Package imm_ext_pkg holds the MODE_SIGN, MODE_ZERO, MODE_BR and MODE_UPPER 2-bit constants and a mode typedef. The top module imports it.
- One combinational sub-module, imm_ext_core (IN_W, OUT_W; imm, mode → ext), contains all extension arithmetic. It is reusable by the branch-target adder.
- FIFO storage, pointers and the handshake stay in imm_extend_pipe.

Test Plan:
1. Mode mapping, all with defaults and out_ready=1: SIGN 16'h0000→32'h00000000; SIGN 16'h0001→32'h00000001; SIGN 16'h00FB→32'h000000FB; SIGN 16'hDB39→32'hFFFFDB39; ZERO 16'hDB39→32'h0000DB39; BR 16'hDB39→32'hFFFF6CE4; BR 16'h0001→32'h00000004; UPPER 16'h0007→32'h00070000; UPPER 16'hDB39→32'hDB390000. Each result appears one cycle after acceptance with the matching tag.
2. Backpressure with out_ready=0: push 3 operands (tags 1,2,3) → only 2 accepted, in_ready=0 at count=2. Raise out_ready → results are emitted in order with tags 1,2, then in_ready=1.
3. Streaming with in_valid=1 and out_ready=1 for 20 cycles → count settles at 1, one result per cycle, no gaps. Also exercise pointer wrap with DEPTH=3.
4. Stall hold: with out_valid=1, drop out_ready for 5 cycles → out_data and out_tag stay constant and count does not decrement.
5. Reset mid-operation: at count=2, pulse rst_n low between clock edges → out_valid=0, count=0, out_data=0 immediately. After release, the first push of SIGN 16'h8000 gives 32'hFFFF8000.
6. Parameter sweep with IN_W=12, OUT_W=16: SIGN 12'h800→16'hF800; UPPER 12'hABC→16'hABC0; BR 12'hFFF→16'hFFFC.
